// File: rtl/sockit_spi_pkg.sv
// sockit_spi_pkg: shared arbiter state type and default watchdog limit.
package sockit_spi_pkg;
   typedef enum logic [1:0] {IDLE, G0, G1} arb_st_t;
   localparam logic [15:0] TMO_DEF = 16'd1024;
endpackage

// File: rtl/sockit_spi_obuf.sv
// sockit_spi_obuf: single-entry vld/rdy output register; a load overrides a drain.
module sockit_spi_obuf #(
   parameter int DW = 32
) (
   input  logic          ACLK,
   input  logic          ARESETn,
   input  logic          ld,
   input  logic [DW-1:0] din,
   input  logic          rdy,
   output logic          vld,
   output logic [DW-1:0] dat
);
   always_ff @(posedge ACLK or negedge ARESETn)
      if (!ARESETn) begin
         vld <= 1'b0;
         dat <= '0;
      end else if (ld) begin
         vld <= 1'b1;
         dat <= din;
      end else if (rdy)
         vld <= 1'b0;
endmodule

// File: rtl/sockit_spi_cmd_arb.sv
// sockit_spi_cmd_arb: two-requester packet arbiter feeding the SPI sequencer.
// Optional stall watchdog enabled by defining SOCKIT_SPI_ARB_WDG_EN.
module sockit_spi_cmd_arb
   import sockit_spi_pkg::*;
#(
   parameter int          DW  = 32,
   parameter int          PRI = 0,
   parameter logic [15:0] TMO = TMO_DEF
) (
   input  logic          ACLK,
   input  logic          ARESETn,
   input  logic          r0_vld,
   input  logic [DW-1:0] r0_dat,
   input  logic          r0_lst,
   output logic          r0_rdy,
   input  logic          r1_vld,
   input  logic [DW-1:0] r1_dat,
   input  logic          r1_lst,
   output logic          r1_rdy,
   output logic          scw_vld,
   output logic [DW-1:0] scw_dat,
   input  logic          scw_rdy,
   output logic [1:0]    gnt,
   output logic          busy,
   output logic          err,
   input  logic          err_clr
);
   arb_st_t st;
   logic    last1, acc, x0, x1, xfer, done, pick1;
   logic [DW-1:0] din;
   assign acc    = ~scw_vld | scw_rdy;
   assign r0_rdy = (st == G0) & acc;
   assign r1_rdy = (st == G1) & acc;
   assign x0     = r0_vld & r0_rdy;
   assign x1     = r1_vld & r1_rdy;
   assign xfer   = x0 | x1;
   assign din    = x1 ? r1_dat : r0_dat;
   assign done   = (x0 & r0_lst) | (x1 & r1_lst);
   // r1 wins alone, or on a round-robin tie when r0 was served last
   assign pick1  = r1_vld & (~r0_vld | (PRI == 0 && !last1));
   assign busy   = (st != IDLE) | scw_vld;
   always_ff @(posedge ACLK or negedge ARESETn)
      if (!ARESETn) begin
         st    <= IDLE;
         gnt   <= 2'b00;
         last1 <= 1'b1;
      end else if (st == IDLE) begin
         if (r0_vld | r1_vld) begin
            st    <= pick1 ? G1 : G0;
            gnt   <= pick1 ? 2'b10 : 2'b01;
            last1 <= pick1;
         end
      end else if (done) begin
         st  <= IDLE;
         gnt <= 2'b00;
      end
   sockit_spi_obuf #(.DW(DW)) u_obuf (
      .ACLK    (ACLK),
      .ARESETn (ARESETn),
      .ld      (xfer),
      .din     (din),
      .rdy     (scw_rdy),
      .vld     (scw_vld),
      .dat     (scw_dat)
   );
`ifdef SOCKIT_SPI_ARB_WDG_EN
   logic [15:0] cnt;
   logic        stall;
   assign stall = (st == G0 & ~r0_vld) | (st == G1 & ~r1_vld);
   // counter parks at TMO so a cleared err is not re-raised by the same stall
   always_ff @(posedge ACLK or negedge ARESETn)
      if (!ARESETn) begin
         cnt <= '0;
         err <= 1'b0;
      end else begin
         cnt <= (st == IDLE || xfer) ? 16'd0 : (stall && cnt != TMO) ? cnt + 16'd1 : cnt;
         err <= err_clr ? 1'b0 : err | (stall && cnt != TMO && cnt + 16'd1 == TMO);
      end
`else
   logic unused_wdg;
   assign unused_wdg = err_clr | (|TMO);
   assign err = 1'b0;
`endif
endmodule

// File: tb/tb_sockit_spi_cmd_arb.sv
// tb_sockit_spi_cmd_arb: scoreboard bench for the command arbiter (PRI=0, TMO=8).
module tb_sockit_spi_cmd_arb;
   logic        ACLK = 1'b0, ARESETn;
   logic        r0_vld, r0_lst, r0_rdy, r1_vld, r1_lst, r1_rdy;
   logic [31:0] r0_dat, r1_dat, scw_dat;
   logic        scw_vld, scw_rdy, busy, err, err_clr;
   logic [1:0]  gnt;
   logic [31:0] sbq[$];
   int          out_t[$];
   int          cyc = 0, n_cmp = 0, n_bad = 0, t0;
`ifdef SOCKIT_SPI_ARB_WDG_EN
   localparam logic WDG = 1'b1;
`else
   localparam logic WDG = 1'b0;
`endif

   sockit_spi_cmd_arb #(.DW(32), .PRI(0), .TMO(16'd8)) dut (
      .ACLK(ACLK), .ARESETn(ARESETn),
      .r0_vld(r0_vld), .r0_dat(r0_dat), .r0_lst(r0_lst), .r0_rdy(r0_rdy),
      .r1_vld(r1_vld), .r1_dat(r1_dat), .r1_lst(r1_lst), .r1_rdy(r1_rdy),
      .scw_vld(scw_vld), .scw_dat(scw_dat), .scw_rdy(scw_rdy),
      .gnt(gnt), .busy(busy), .err(err), .err_clr(err_clr)
   );

   always #5 ACLK = ~ACLK;
   always @(posedge ACLK) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(negedge ACLK)
      if (ARESETn === 1'b1 && scw_vld && scw_rdy) begin
         out_t.push_back(cyc);
         if (sbq.size() == 0) chk("sb_underflow", 64'(sbq.size()), 1);
         else chk("scw_dat", scw_dat, sbq.pop_front());
      end

   task automatic wait_rdy(input int r);
      int t = 0;
      @(negedge ACLK);
      while (!(r == 0 ? r0_rdy : r1_rdy) && t < 60) begin
         @(negedge ACLK);
         t++;
      end
      if (t >= 60) chk("hs_timeout", t, 0);
   endtask

   task automatic send(input int r, input int n, input logic [31:0] base);
      for (int i = 0; i < n; i++) begin
         if (r == 0) begin r0_vld = 1; r0_dat = base + i; r0_lst = (i == n - 1); end
         else begin r1_vld = 1; r1_dat = base + i; r1_lst = (i == n - 1); end
         wait_rdy(r);
         if (r == 0 ? r0_rdy : r1_rdy) chk("gnt", gnt, r == 0 ? 64'd1 : 64'd2);
         @(posedge ACLK); #1;
      end
      if (r == 0) begin r0_vld = 0; r0_lst = 0; end
      else begin r1_vld = 0; r1_lst = 0; end
   endtask

   task automatic wait_out(input int n);
      int t = 0;
      while (out_t.size() < n && t < 100) begin
         @(negedge ACLK);
         t++;
      end
      if (out_t.size() < n) chk("out_timeout", 64'(out_t.size()), 64'(n));
      @(posedge ACLK); #1;
   endtask

   task automatic pulse_reset();
      ARESETn = 0;
      @(posedge ACLK); #1;
      ARESETn = 1;
      @(posedge ACLK); #1;
   endtask

   initial begin
      ARESETn = 0; r0_vld = 0; r0_dat = 0; r0_lst = 0; r1_vld = 0; r1_dat = 0; r1_lst = 0;
      scw_rdy = 1; err_clr = 0;
      repeat (2) @(posedge ACLK); #1;
      chk("rst_vld", scw_vld, 0); chk("rst_dat", scw_dat, 0); chk("rst_gnt", gnt, 0);
      chk("rst_busy", busy, 0); chk("rst_err", err, 0); chk("rst_r0rdy", r0_rdy, 0);
      chk("rst_r1rdy", r1_rdy, 0);
      ARESETn = 1;
      @(posedge ACLK); #1;
      // three-beat packet, latency and back-to-back output
      sbq.push_back(32'hA1); sbq.push_back(32'hA2); sbq.push_back(32'hA3);
      out_t.delete();
      t0 = cyc;
      send(0, 3, 32'hA1);
      wait_out(3);
      if (out_t.size() >= 3) begin
         chk("t1_latency", out_t[0] - t0, 2);
         chk("t1_beat2", out_t[1] - out_t[0], 1);
         chk("t1_beat3", out_t[2] - out_t[1], 1);
      end
      chk("t1_idle_gnt", gnt, 0);
      // tie from reset: r0 first, one idle cycle, then r1
      pulse_reset();
      sbq.push_back(32'hB0); sbq.push_back(32'hB1); sbq.push_back(32'hC0); sbq.push_back(32'hC1);
      out_t.delete();
      fork
         send(0, 2, 32'hB0);
         send(1, 2, 32'hC0);
      join
      wait_out(4);
      if (out_t.size() >= 4) begin
         chk("t2_b2b", out_t[1] - out_t[0], 1);
         chk("t2_gap", out_t[2] - out_t[1], 2);
      end
      // after r0 alone, a fresh tie goes to r1
      sbq.push_back(32'hD0);
      send(0, 1, 32'hD0);
      sbq.push_back(32'hE0); sbq.push_back(32'hE1); sbq.push_back(32'hF0);
      fork
         send(1, 2, 32'hE0);
         send(0, 1, 32'hF0);
      join
      wait_out(1);
      // r0 arrives mid r1 packet and must wait for r1's last beat
      for (int i = 0; i < 4; i++) sbq.push_back(32'h10 + i);
      for (int i = 0; i < 2; i++) sbq.push_back(32'h20 + i);
      fork
         send(1, 4, 32'h10);
         begin repeat (2) @(posedge ACLK); #1; send(0, 2, 32'h20); end
         repeat (12) @(negedge ACLK) if (gnt == 2'b10) chk("t3_r0_rdy_hold", r0_rdy, 0);
      join
      wait_out(1);
      // downstream backpressure for five cycles mid-packet
      for (int i = 0; i < 4; i++) sbq.push_back(32'h30 + i);
      out_t.delete();
      fork
         send(0, 4, 32'h30);
         begin
            int t = 0;
            while (out_t.size() < 1 && t < 50) begin @(posedge ACLK); t++; end
            #1 scw_rdy = 0;
            repeat (5) begin
               @(negedge ACLK);
               chk("t4_dat", scw_dat, 32'h31);
               chk("t4_vld", scw_vld, 1);
               chk("t4_r0_rdy", r0_rdy, 0);
            end
            @(posedge ACLK); #1 scw_rdy = 1;
         end
      join
      wait_out(4);
      // granted requester stalls for eight cycles
      sbq.push_back(32'h40); sbq.push_back(32'h41);
      r0_vld = 1; r0_dat = 32'h40; r0_lst = 0;
      wait_rdy(0);
      @(posedge ACLK); #1;
      r0_vld = 0;
      repeat (7) @(posedge ACLK); #1;
      chk("t5_err_pre", err, 0);
      @(posedge ACLK); #1;
      chk("t5_err_tmo", err, WDG);
      chk("t5_gnt_held", gnt, 2'b01);
      err_clr = 1;
      @(posedge ACLK); #1;
      err_clr = 0;
      chk("t5_err_clr", err, 0);
      send(0, 1, 32'h41);
      wait_out(1);
      // reset during the second beat discards everything buffered
      r0_vld = 1; r0_dat = 32'h50; r0_lst = 0;
      wait_rdy(0);
      @(posedge ACLK); #1;
      r0_dat = 32'h51;
      #1 ARESETn = 0;
      #1;
      chk("t6_vld", scw_vld, 0); chk("t6_dat", scw_dat, 0); chk("t6_gnt", gnt, 0);
      chk("t6_busy", busy, 0); chk("t6_err", err, 0); chk("t6_r0rdy", r0_rdy, 0);
      r0_vld = 0;
      @(posedge ACLK); #1;
      ARESETn = 1;
      sbq.push_back(32'h60);
      send(1, 1, 32'h60);
      wait_out(1);
      repeat (3) @(posedge ACLK); #1;
      chk("sb_empty", 64'(sbq.size()), 0);
      chk("end_busy", busy, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end
endmodule
